sram_rw_ctrl_256x4w: RTL and testbench
======================================

# sram_rw_ctrl_256x4w

Single-port SRAM controller that sits directly upstream of the 256-set × 4-way × 43-bit single-port array macro. It clears the whole array after reset, arbitrates read and write requests onto the one RW port with writes taking priority, and presents a one-cycle-latency read response. The response data is held stable between reads, so consumers never see macro garbage on idle cycles.

## Interface
Parameters:
- SETS, 256: number of sets (array depth).
- WAYS, 4: number of ways (write-mask width).
- WAY_BITS, 43: bits per way; DATA_W = WAYS*WAY_BITS = 172.
- ADDR_W, 8: log2(SETS).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- io_r_req_valid  in  1  read request.
- io_r_req_ready  out  1  read accepted this cycle.
- io_r_req_bits_setIdx  in  ADDR_W  read set index.
- io_r_resp_valid  out  1  read data valid, one cycle after read fire.
- io_r_resp_data  out  DATA_W  read data; held between reads.
- io_w_req_valid  in  1  write request.
- io_w_req_ready  out  1  write accepted this cycle.
- io_w_req_bits_setIdx  in  ADDR_W  write set index.
- io_w_req_bits_data  in  DATA_W  write data; way i is bits [i*43 +: 43].
- io_w_req_bits_waymask  in  WAYS  per-way write enable.
- io_init_done  out  1  high once the post-reset clear has completed.
- RW0_addr  out  ADDR_W  macro address.
- RW0_en  out  1  macro enable.
- RW0_wmode  out  1  macro write (1) or read (0).
- RW0_wmask  out  WAYS  macro way mask.
- RW0_wdata  out  DATA_W  macro write data.
- RW0_rdata  in  DATA_W  macro read data; valid one cycle after a read enable, undefined otherwise.

## Operation
- FSM states:
  - INIT: entered on reset. Each cycle drives RW0_en=1, RW0_wmode=1, RW0_wmask=all-ones, RW0_wdata=0, RW0_addr=init_cnt. init_cnt increments 0→SETS-1. When init_cnt==SETS-1 is written, the FSM moves to RUN. Both request readys are 0 throughout INIT.
  - RUN: normal operation; the FSM stays here until reset.
- Arbitration in RUN:
  - io_w_req_ready=1 always.
  - io_r_req_ready = !io_w_req_valid, so a write always wins.
  - Write fire drives RW0_en=1, RW0_wmode=1, RW0_wmask=waymask, RW0_wdata=data, RW0_addr=w setIdx.
  - Read fire drives RW0_en=1, RW0_wmode=0, RW0_addr=r setIdx.
  - Otherwise RW0_en=0.
- A write with waymask=0 is still a fire and still blocks the read; the array is unchanged.
- Read response:
  - resp_pending is set on read fire, so io_r_resp_valid equals resp_pending.
  - When io_r_resp_valid=1, io_r_resp_data = RW0_rdata, and the value is also captured into hold_q.
  - When io_r_resp_valid=0, io_r_resp_data = hold_q.
- No read-during-write forwarding. A read issued the cycle after a write to the same set returns the new data, because the macro has already committed it.
- Reset values:
  - State=INIT, init_cnt=0, resp_pending=0, hold_q=0, io_init_done=0.
  - Both readys 0, io_r_resp_valid=0, io_r_resp_data=0.
- Reset mid-operation:
  - Any pending response is dropped (resp_valid=0 the next cycle) and hold_q is cleared.
  - The clear sweep restarts at set 0.
  - Requests presented during reset or INIT are not accepted. The upstream holds them under valid/ready.

## Timing
- Cycle 0 is the first cycle with reset low; it writes set 0 in INIT.
- Set 255 is written at cycle 255. io_init_done and both readys may go high at cycle 256.
- Read latency is 1: fire in cycle N gives io_r_resp_valid=1 with data in cycle N+1.
- Throughput is one operation per cycle. Back-to-back reads give back-to-back responses.
- All control outputs are registered except the RW0_* drives and the readys, which are combinational from state and request valids.
- io_r_resp_data is combinational from RW0_rdata only when resp_valid=1.

## Structure
- Shared package: SETS, WAYS, WAY_BITS, ADDR_W, DATA_W constants and the FSM state enum (INIT, RUN).
- One natural sub-module: sram_init_sweeper, which holds the init_cnt counter and the done flag. Everything else (arbiter, response pipe, hold register) is inline.
- The macro is instantiated by the parent, not inside this block.

## Test plan
- Reset release: count RW0_en&&RW0_wmode cycles with wmask=4'hF and wdata=0 → exactly 256, addresses 0..255 in order; io_init_done rises at cycle 256; any read afterwards returns 0.
- Write set 0x3A with data = way i filled with i+1 and waymask=4'hF, then read 0x3A → resp_valid one cycle later with that data.
- Partial mask: write set 0x10 all-ones with mask 4'hF, then write zeros with mask 4'b0101, then read → ways 1 and 3 all-ones, ways 0 and 2 zero.
- Collision: w_valid and r_valid both high on one cycle → write fires, r_req_ready=0, no resp_valid next cycle; the read fires the following cycle once w_valid drops.
- Hold: read set 5 (data D), then 10 idle cycles with the macro rdata randomized → io_r_resp_data stays D and resp_valid=0.
- Reset mid-run: assert reset on the cycle a read fires → no resp_valid afterwards, resp_data=0, and a full 256-cycle sweep repeats before the readys rise.

Source files
------------

// File: rtl/sram_rw_ctrl_256x4w_pkg.sv
// Shared constants and FSM state type for the 256-set x 4-way SRAM controller.
//   SETS/WAYS/WAY_BITS : array geometry of the single-port macro
//   ADDR_W/DATA_W      : derived address and full-row data widths
//   ctrl_state_e       : controller FSM states
package sram_rw_ctrl_256x4w_pkg;

  localparam int SETS     = 256;
  localparam int WAYS     = 4;
  localparam int WAY_BITS = 43;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = WAYS * WAY_BITS;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sram_rw_ctrl_256x4w_sweeper.sv
// Post-reset clear sweep counter for the SRAM controller.
//   clock, reset : sole clock, synchronous active-high reset
//   init_cnt     : set index being cleared this cycle
//   init_last    : high on the cycle the final set is cleared
//   init_done    : registered; high once every set has been cleared
module sram_init_sweeper
  import sram_rw_ctrl_256x4w_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] init_cnt,
  output logic              init_last,
  output logic              init_done
);

  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;

  assign init_cnt  = cnt_q;
  assign init_last = !done_q && (cnt_q == ADDR_W'(SETS - 1));
  assign init_done = done_q;

  // The counter freezes once done so the sweep runs exactly once per reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (init_last) done_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_rw_ctrl_256x4w.sv
// Single-port SRAM controller: clears the array after reset, arbitrates
// read/write requests onto the RW0 port (write wins), and returns read data
// one cycle after the read fires, holding it stable between reads.
//   clock, reset        : sole clock, synchronous active-high reset
//   io_r_req_*          : read request (valid/ready, set index)
//   io_r_resp_*         : read response (valid one cycle after fire, data)
//   io_w_req_*          : write request (valid/ready, set index, data, waymask)
//   io_init_done        : clear sweep finished
//   RW0_*               : single-port macro drive and read data
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | clearing the array one set per cycle; requests not accepted
// RUN   | normal operation; writes take priority over reads
module sram_rw_ctrl_256x4w
  import sram_rw_ctrl_256x4w_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_r_req_valid,
  output logic              io_r_req_ready,
  input  logic [ADDR_W-1:0] io_r_req_bits_setIdx,
  output logic              io_r_resp_valid,
  output logic [DATA_W-1:0] io_r_resp_data,
  input  logic              io_w_req_valid,
  output logic              io_w_req_ready,
  input  logic [ADDR_W-1:0] io_w_req_bits_setIdx,
  input  logic [DATA_W-1:0] io_w_req_bits_data,
  input  logic [WAYS-1:0]   io_w_req_bits_waymask,
  output logic              io_init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [WAYS-1:0]   RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] init_cnt;
  logic              init_last;
  logic              r_fire;
  logic              resp_pending_q;
  logic [DATA_W-1:0] hold_q;

  sram_init_sweeper u_sweeper (
    .clock     (clock),
    .reset     (reset),
    .init_cnt  (init_cnt),
    .init_last (init_last),
    .init_done (io_init_done)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    io_w_req_ready = 1'b0;
    io_r_req_ready = 1'b0;
    RW0_en         = 1'b0;
    RW0_wmode      = 1'b0;
    RW0_wmask      = '0;
    RW0_wdata      = '0;
    RW0_addr       = '0;
    unique case (state_q)
      INIT: begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_wmask = '1;
        RW0_addr  = init_cnt;
        if (init_last) state_d = RUN;
      end
      RUN: begin
        io_w_req_ready = 1'b1;
        io_r_req_ready = !io_w_req_valid;
        if (io_w_req_valid) begin
          // A zero waymask still occupies the port and blocks the read.
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_wmask = io_w_req_bits_waymask;
          RW0_wdata = io_w_req_bits_data;
          RW0_addr  = io_w_req_bits_setIdx;
        end else if (io_r_req_valid) begin
          RW0_en   = 1'b1;
          RW0_addr = io_r_req_bits_setIdx;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign r_fire = io_r_req_valid && io_r_req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_pending_q <= 1'b0;
      hold_q         <= '0;
    end else begin
      resp_pending_q <= r_fire;
      if (resp_pending_q) hold_q <= RW0_rdata;
    end
  end

  // Macro rdata is only meaningful the cycle after a read; otherwise replay
  // the last captured response so consumers never see garbage.
  assign io_r_resp_valid = resp_pending_q;
  assign io_r_resp_data  = resp_pending_q ? RW0_rdata : hold_q;

endmodule

// File: tb/tb_sram_rw_ctrl_256x4w.sv
module tb_sram_rw_ctrl_256x4w;
  import sram_rw_ctrl_256x4w_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_r_req_valid;
  logic              io_r_req_ready;
  logic [ADDR_W-1:0] io_r_req_bits_setIdx;
  logic              io_r_resp_valid;
  logic [DATA_W-1:0] io_r_resp_data;
  logic              io_w_req_valid;
  logic              io_w_req_ready;
  logic [ADDR_W-1:0] io_w_req_bits_setIdx;
  logic [DATA_W-1:0] io_w_req_bits_data;
  logic [WAYS-1:0]   io_w_req_bits_waymask;
  logic              io_init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [WAYS-1:0]   RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  int total = 0;
  int bad   = 0;

  // Macro model (environment, not the reference).
  logic [DATA_W-1:0] macro_mem [SETS];
  // Reference: contents the bench expects the array to hold.
  logic [DATA_W-1:0] ref_mem [SETS];
  logic [DATA_W-1:0] exp_hold;

  sram_rw_ctrl_256x4w dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_r_req_valid        (io_r_req_valid),
    .io_r_req_ready        (io_r_req_ready),
    .io_r_req_bits_setIdx  (io_r_req_bits_setIdx),
    .io_r_resp_valid       (io_r_resp_valid),
    .io_r_resp_data        (io_r_resp_data),
    .io_w_req_valid        (io_w_req_valid),
    .io_w_req_ready        (io_w_req_ready),
    .io_w_req_bits_setIdx  (io_w_req_bits_setIdx),
    .io_w_req_bits_data    (io_w_req_bits_data),
    .io_w_req_bits_waymask (io_w_req_bits_waymask),
    .io_init_done          (io_init_done),
    .RW0_addr              (RW0_addr),
    .RW0_en                (RW0_en),
    .RW0_wmode             (RW0_wmode),
    .RW0_wmask             (RW0_wmask),
    .RW0_wdata             (RW0_wdata),
    .RW0_rdata             (RW0_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] rand_row();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  always @(posedge clock) begin
    if (RW0_en && RW0_wmode) begin
      for (int w = 0; w < WAYS; w++)
        if (RW0_wmask[w]) macro_mem[RW0_addr][w*WAY_BITS +: WAY_BITS] <= RW0_wdata[w*WAY_BITS +: WAY_BITS];
    end
    if (RW0_en && !RW0_wmode) RW0_rdata <= macro_mem[RW0_addr];
    else                      RW0_rdata <= rand_row();
  end

  function automatic void ref_write(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] d,
                                    input logic [WAYS-1:0] m);
    for (int w = 0; w < WAYS; w++)
      if (m[w]) ref_mem[idx][w*WAY_BITS +: WAY_BITS] = d[w*WAY_BITS +: WAY_BITS];
  endfunction

  function automatic void ref_clear();
    for (int s = 0; s < SETS; s++) ref_mem[s] = '0;
  endfunction

  // Drive helpers: start at a negedge, end at the next negedge with the request dropped.
  task automatic do_write(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] d,
                          input logic [WAYS-1:0] m);
    io_w_req_valid = 1'b1;
    io_w_req_bits_setIdx = idx;
    io_w_req_bits_data = d;
    io_w_req_bits_waymask = m;
    @(negedge clock);
    io_w_req_valid = 1'b0;
    ref_write(idx, d, m);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] idx);
    io_r_req_valid = 1'b1;
    io_r_req_bits_setIdx = idx;
    @(negedge clock);
    io_r_req_valid = 1'b0;
    exp_hold = ref_mem[idx];
  endtask

  // Observes the 256 sweep cycles starting at cycle 0 (called at negedge+1).
  task automatic run_sweep(output int writes, output int order_err, output int early);
    writes = 0; order_err = 0; early = 0;
    for (int i = 0; i < SETS; i++) begin
      if (RW0_en && RW0_wmode && RW0_wmask == 4'hF && RW0_wdata == '0) writes++;
      if (RW0_addr != ADDR_W'(i)) order_err++;
      if (io_r_req_ready || io_w_req_ready || io_init_done) early++;
      @(negedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    int writes, order_err, early;
    reset = 1'b1;
    io_w_req_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    total++; if (io_w_req_ready !== 1'b0 || io_r_req_ready !== 1'b0) begin bad++;
      $display("FAIL reset_readys: got w=%b r=%b want 0 0", io_w_req_ready, io_r_req_ready); end
    total++; if (io_init_done !== 1'b0) begin bad++;
      $display("FAIL reset_init_done: got %b want 0", io_init_done); end
    total++; if (io_r_resp_valid !== 1'b0 || io_r_resp_data !== '0) begin bad++;
      $display("FAIL reset_resp: got v=%b d=%h want 0 0", io_r_resp_valid, io_r_resp_data); end
    io_w_req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    run_sweep(writes, order_err, early);
    total++; if (writes !== 256) begin bad++;
      $display("FAIL sweep_writes: got %0d want 256", writes); end
    total++; if (order_err !== 0) begin bad++;
      $display("FAIL sweep_order: got %0d bad addrs want 0", order_err); end
    total++; if (early !== 0) begin bad++;
      $display("FAIL sweep_early_ready: got %0d cycles want 0", early); end
    total++; if (io_init_done !== 1'b1 || io_w_req_ready !== 1'b1 || io_r_req_ready !== 1'b1 || RW0_en !== 1'b0) begin bad++;
      $display("FAIL init_done_256: got done=%b wr=%b rr=%b en=%b want 1 1 1 0",
               io_init_done, io_w_req_ready, io_r_req_ready, RW0_en); end
    ref_clear();
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      logic [ADDR_W-1:0] idx;
      idx = ADDR_W'($urandom_range(0, SETS - 1));
      do_read(idx);
      total++; if (io_r_resp_valid !== 1'b1 || io_r_resp_data !== '0) begin bad++;
        $display("FAIL cleared_read: set %h got v=%b d=%h want 1 0", idx, io_r_resp_valid, io_r_resp_data); end
    end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] pat;
    for (int w = 0; w < WAYS; w++) pat[w*WAY_BITS +: WAY_BITS] = WAY_BITS'(w + 1);
    do_write(8'h3A, pat, 4'hF);
    do_read(8'h3A);
    total++; if (io_r_resp_valid !== 1'b1 || io_r_resp_data !== pat) begin bad++;
      $display("FAIL write_read: got v=%b d=%h want 1 %h", io_r_resp_valid, io_r_resp_data, pat); end
  endtask

  task automatic test_partial_mask();
    logic [DATA_W-1:0] expv;
    expv = '0;
    expv[1*WAY_BITS +: WAY_BITS] = '1;
    expv[3*WAY_BITS +: WAY_BITS] = '1;
    do_write(8'h10, '1, 4'hF);
    do_write(8'h10, '0, 4'b0101);
    do_read(8'h10);
    total++; if (io_r_resp_data !== expv) begin bad++;
      $display("FAIL partial_mask: got %h want %h", io_r_resp_data, expv); end
    do_write(8'h10, rand_row(), 4'b0000);
    do_read(8'h10);
    total++; if (io_r_resp_data !== expv) begin bad++;
      $display("FAIL zero_mask: got %h want %h", io_r_resp_data, expv); end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] d;
    d = rand_row();
    io_w_req_valid = 1'b1; io_w_req_bits_setIdx = 8'h20; io_w_req_bits_data = d; io_w_req_bits_waymask = 4'hF;
    io_r_req_valid = 1'b1; io_r_req_bits_setIdx = 8'h3A;
    #1;
    total++; if (io_r_req_ready !== 1'b0 || io_w_req_ready !== 1'b1 || RW0_wmode !== 1'b1 || RW0_addr !== 8'h20) begin bad++;
      $display("FAIL collision_arb: got rr=%b wr=%b wmode=%b addr=%h want 0 1 1 20",
               io_r_req_ready, io_w_req_ready, RW0_wmode, RW0_addr); end
    @(negedge clock);
    ref_write(8'h20, d, 4'hF);
    io_w_req_valid = 1'b0;
    #1;
    total++; if (io_r_resp_valid !== 1'b0) begin bad++;
      $display("FAIL collision_no_resp: got %b want 0", io_r_resp_valid); end
    total++; if (io_r_req_ready !== 1'b1 || RW0_en !== 1'b1 || RW0_wmode !== 1'b0 || RW0_addr !== 8'h3A) begin bad++;
      $display("FAIL collision_retry: got rr=%b en=%b wmode=%b addr=%h want 1 1 0 3a",
               io_r_req_ready, RW0_en, RW0_wmode, RW0_addr); end
    @(negedge clock);
    io_r_req_valid = 1'b0;
    exp_hold = ref_mem[8'h3A];
    total++; if (io_r_resp_valid !== 1'b1 || io_r_resp_data !== exp_hold) begin bad++;
      $display("FAIL collision_resp: got v=%b d=%h want 1 %h", io_r_resp_valid, io_r_resp_data, exp_hold); end
  endtask

  task automatic test_hold();
    logic [DATA_W-1:0] d;
    d = rand_row();
    do_write(8'h05, d, 4'hF);
    do_read(8'h05);
    total++; if (io_r_resp_valid !== 1'b1 || io_r_resp_data !== d) begin bad++;
      $display("FAIL hold_read: got v=%b d=%h want 1 %h", io_r_resp_valid, io_r_resp_data, d); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      total++; if (io_r_resp_valid !== 1'b0 || io_r_resp_data !== d) begin bad++;
        $display("FAIL hold_idle: cycle %0d got v=%b d=%h want 0 %h", k, io_r_resp_valid, io_r_resp_data, d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] idx [8];
    for (int k = 0; k < 8; k++) begin
      idx[k] = ADDR_W'(8'h80 + k);
      do_write(idx[k], rand_row(), WAYS'($urandom_range(0, 15)));
    end
    io_r_req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      io_r_req_bits_setIdx = idx[k];
      @(negedge clock);
      total++; if (io_r_resp_valid !== 1'b1 || io_r_resp_data !== ref_mem[idx[k]]) begin bad++;
        $display("FAIL back_to_back: set %h got v=%b d=%h want 1 %h", idx[k], io_r_resp_valid,
                 io_r_resp_data, ref_mem[idx[k]]); end
    end
    io_r_req_valid = 1'b0;
    exp_hold = ref_mem[idx[7]];
  endtask

  task automatic test_random();
    logic wv, rv, rfire;
    logic [ADDR_W-1:0] ridx, widx;
    logic [DATA_W-1:0] wd;
    logic [WAYS-1:0] wm;
    for (int k = 0; k < 200; k++) begin
      wv = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 1) == 0);
      ridx = ADDR_W'($urandom_range(0, 7));
      widx = ADDR_W'($urandom_range(0, 7));
      wd = rand_row();
      wm = WAYS'($urandom_range(0, 15));
      io_w_req_valid = wv; io_w_req_bits_setIdx = widx; io_w_req_bits_data = wd; io_w_req_bits_waymask = wm;
      io_r_req_valid = rv; io_r_req_bits_setIdx = ridx;
      #1;
      total++; if (io_r_req_ready !== !wv) begin bad++;
        $display("FAIL rand_rready: iter %0d got %b want %b", k, io_r_req_ready, !wv); end
      rfire = rv && !wv;
      if (rfire) exp_hold = ref_mem[ridx];
      if (wv) ref_write(widx, wd, wm);
      @(negedge clock);
      total++; if (io_r_resp_valid !== rfire || io_r_resp_data !== exp_hold) begin bad++;
        $display("FAIL rand_resp: iter %0d got v=%b d=%h want %b %h", k, io_r_resp_valid,
                 io_r_resp_data, rfire, exp_hold); end
    end
    io_w_req_valid = 1'b0;
    io_r_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int writes, order_err, early;
    io_r_req_valid = 1'b1;
    io_r_req_bits_setIdx = 8'h3A;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (io_r_resp_valid !== 1'b0 || io_r_resp_data !== '0) begin bad++;
      $display("FAIL midreset_resp: got v=%b d=%h want 0 0", io_r_resp_valid, io_r_resp_data); end
    run_sweep(writes, order_err, early);
    total++; if (writes !== 256 || order_err !== 0) begin bad++;
      $display("FAIL midreset_sweep: got writes=%0d order_err=%0d want 256 0", writes, order_err); end
    total++; if (early !== 0) begin bad++;
      $display("FAIL midreset_early_ready: got %0d cycles want 0", early); end
    total++; if (io_init_done !== 1'b1 || io_r_req_ready !== 1'b1) begin bad++;
      $display("FAIL midreset_done: got done=%b rr=%b want 1 1", io_init_done, io_r_req_ready); end
    ref_clear();
    @(negedge clock);
    io_r_req_valid = 1'b0;
    total++; if (io_r_resp_valid !== 1'b1 || io_r_resp_data !== '0) begin bad++;
      $display("FAIL midreset_cleared: got v=%b d=%h want 1 0", io_r_resp_valid, io_r_resp_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < SETS; s++) macro_mem[s] = rand_row();
    RW0_rdata = '0;
    exp_hold = '0;
    reset = 1'b1;
    io_r_req_valid = 1'b0;
    io_r_req_bits_setIdx = '0;
    io_w_req_valid = 1'b0;
    io_w_req_bits_setIdx = '0;
    io_w_req_bits_data = '0;
    io_w_req_bits_waymask = '0;
    @(negedge clock);
    test_reset();
    test_write_read();
    test_partial_mask();
    test_collision();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
